// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arbState_t;

    // Bus turnaround length, in cycles, between one owner and the next.
    localparam int TURN_CYCLES = 1;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit keeps ptr+i exact so non-power-of-two sizes wrap correctly.
            sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin tri-state bus arbiter with an IDLE/OWN/TURN handover sequence.
// Define ARB_TIMEOUT_EN to bound ownership to HOLD_MAX cycles with a timeout pulse.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busEn,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       timeout
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arbState_t          state;
    arbState_t          stateNext;
    logic [NUM_REQ-1:0] grantNext;
    logic [NUM_REQ-1:0] winOneHot;
    logic [PTR_W-1:0]   ownerNext;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptrNext;
    logic [PTR_W-1:0]   winIdx;
    logic               winValid;
    logic               ownerDone;
    logic               holdExpire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winOneHot),
        .valid  (winValid)
    );

    always_comb begin
        winIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winOneHot[i]) begin
                winIdx = PTR_W'(i);
            end
        end
    end

    // Only the current owner's req/done can end a tenure.
    assign ownerDone = done[owner] | ~req[owner];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] holdCnt;
    logic       timeoutNext;

    assign holdExpire  = (holdCnt == 8'(HOLD_MAX - 1));
    // A normal release in the expiry cycle wins, so no timeout is flagged.
    assign timeoutNext = (state == OWN) && !ownerDone && holdExpire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holdCnt <= '0;
            timeout <= 1'b0;
        end else begin
            holdCnt <= (state == OWN) ? holdCnt + 8'd1 : 8'd0;
            timeout <= timeoutNext;
        end
    end
`else
    assign holdExpire = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        grantNext = grant;
        ownerNext = owner;
        ptrNext   = ptr;
        case (state)
            IDLE: begin
                if (winValid) begin
                    stateNext = OWN;
                    grantNext = winOneHot;
                    ownerNext = winIdx;
                    ptrNext   = (winIdx == PTR_W'(NUM_REQ - 1)) ? '0 : winIdx + PTR_W'(1);
                end
            end
            OWN: begin
                if (ownerDone || holdExpire) begin
                    stateNext = TURN;
                    grantNext = '0;
                    ownerNext = '0;
                end
            end
            TURN: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
                grantNext = '0;
                ownerNext = '0;
            end
        endcase
    end

    // busEn is registered from the next grant so it tracks grant exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            busEn <= 1'b0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= stateNext;
            grant <= grantNext;
            busEn <= |grantNext;
            owner <= ownerNext;
            ptr   <= ptrNext;
        end
    end

    assign busy = (state == OWN) || (state == TURN);

endmodule
